// File: rtl/snoop_req_initiator_pkg.sv
// ============================================================================
// snoop_req_initiator_pkg : ACE snoop channel types and snoop FSM encoding
// Revision : 1.0
// ============================================================================
`default_nettype none

package snoop_req_initiator_pkg;

  localparam int unsigned DCACHE_LINE_WIDTH  = 128;
  localparam int unsigned DCACHE_BYTE_OFFSET = $clog2(DCACHE_LINE_WIDTH / 8);
  localparam int unsigned SNOOP_DATA_WIDTH   = 64;
  localparam int unsigned SNOOP_BEATS        = DCACHE_LINE_WIDTH / 64;

  typedef logic [3:0] acsnoop_t;

  localparam acsnoop_t SNP_READ_ONCE     = 4'b0000;
  localparam acsnoop_t SNP_READ_SHARED   = 4'b0001;
  localparam acsnoop_t SNP_READ_UNIQUE   = 4'b0111;
  localparam acsnoop_t SNP_CLEAN_INVALID = 4'b1001;
  localparam acsnoop_t SNP_MAKE_INVALID  = 4'b1101;

  // Bit order matches CRRESP[4:0]: DataTransfer is bit 0.
  typedef struct packed {
    logic WasUnique;
    logic IsShared;
    logic PassDirty;
    logic Error;
    logic DataTransfer;
  } crresp_t;

  typedef struct packed {
    logic [63:0] addr;
    acsnoop_t    snoop;
    logic [2:0]  prot;
  } ac_chan_t;

  typedef struct packed {
    logic [SNOOP_DATA_WIDTH-1:0] data;
    logic                        last;
  } cd_chan_t;

  typedef struct packed {
    logic     ac_valid;
    ac_chan_t ac;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic     ac_ready;
    logic     cr_valid;
    crresp_t  cr_resp;
    logic     cd_valid;
    cd_chan_t cd;
  } snoop_resp_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_AC = 2'd1,
    COLLECT = 2'd2,
    RESP    = 2'd3
  } snoop_state_e;

endpackage

`default_nettype wire

// File: rtl/snoop_req_initiator.sv
// ============================================================================
// snoop_req_initiator : issues one AC snoop, collects CR response and CD line
// Revision : 1.0
// ============================================================================
`default_nettype none

module snoop_req_initiator
  import snoop_req_initiator_pkg::*;
#(
  parameter int unsigned LINE_WIDTH     = DCACHE_LINE_WIDTH,
  parameter int unsigned DATA_WIDTH     = SNOOP_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [63:0]           req_addr_i,
  input  acsnoop_t              req_snoop_i,
  output snoop_req_t            snoop_port_o,
  input  snoop_resp_t           snoop_port_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output crresp_t               resp_cr_o,
  output logic [LINE_WIDTH-1:0] resp_data_o,
  output logic                  resp_err_o,
  output logic                  busy_o
);

  localparam int unsigned c_beats = LINE_WIDTH / DATA_WIDTH;
  localparam int unsigned c_bw    = $clog2(c_beats + 1);
  localparam int unsigned c_off   = $clog2(LINE_WIDTH / 8);
  localparam int unsigned c_tw    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [63:0] c_addr_mask = ~((64'd1 << c_off) - 64'd1);

  if ((LINE_WIDTH != c_beats * DATA_WIDTH) || (DATA_WIDTH != SNOOP_DATA_WIDTH)) begin : g_width_check
    $error("snoop_req_initiator: LINE_WIDTH must equal BEATS*DATA_WIDTH with 64-bit CD beats");
  end

  snoop_state_e          r_state, w_state_nxt;
  logic [63:0]           r_addr;
  acsnoop_t              r_snoop;
  crresp_t               r_cr;
  logic                  r_cr_got;
  logic [LINE_WIDTH-1:0] r_data;
  logic [c_bw-1:0]       r_beat_cnt;
  logic                  r_err;
  logic [c_tw-1:0]       r_to_cnt;

  logic            w_collect, w_cr_hs, w_cd_hs, w_cr_got_nxt;
  crresp_t         w_cr_nxt;
  logic [c_bw-1:0] w_beat_nxt;
  logic            w_done, w_timeout, w_last_bad, w_dt0_bad, w_err_set;

  assign w_collect    = (r_state == COLLECT);
  assign w_cr_hs      = w_collect && !r_cr_got && snoop_port_i.cr_valid;
  assign w_cd_hs      = w_collect && (r_beat_cnt < c_bw'(c_beats)) && snoop_port_i.cd_valid;
  assign w_cr_got_nxt = r_cr_got | w_cr_hs;
  assign w_cr_nxt     = w_cr_hs ? snoop_port_i.cr_resp : r_cr;
  assign w_beat_nxt   = r_beat_cnt + c_bw'(w_cd_hs);

  // Completion looks at this cycle's handshakes so the result registers immediately.
  assign w_done     = w_cr_got_nxt && (!w_cr_nxt.DataTransfer || (w_beat_nxt == c_bw'(c_beats)));
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_to_cnt == c_tw'(TIMEOUT_CYCLES - 1));
  assign w_last_bad = w_cd_hs && (snoop_port_i.cd.last != (r_beat_cnt == c_bw'(c_beats - 1)));
  assign w_dt0_bad  = w_cr_got_nxt && !w_cr_nxt.DataTransfer && (w_beat_nxt != '0);
  assign w_err_set  = w_last_bad | w_dt0_bad | (w_cr_hs & snoop_port_i.cr_resp.Error)
                    | (w_timeout & !w_done);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt           = r_state;
    req_ready_o           = 1'b0;
    resp_valid_o          = 1'b0;
    snoop_port_o          = '0;
    snoop_port_o.ac.addr  = r_addr;
    snoop_port_o.ac.snoop = r_snoop;
    case (r_state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) w_state_nxt = SEND_AC;
      end
      SEND_AC: begin
        snoop_port_o.ac_valid = 1'b1;
        if (snoop_port_i.ac_ready) w_state_nxt = COLLECT;
      end
      COLLECT: begin
        snoop_port_o.cr_ready = !r_cr_got;
        snoop_port_o.cd_ready = (r_beat_cnt < c_bw'(c_beats));
        if (w_done || w_timeout) w_state_nxt = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr     <= '0;
      r_snoop    <= '0;
      r_cr       <= '0;
      r_cr_got   <= 1'b0;
      r_data     <= '0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
      r_to_cnt   <= '0;
    end else begin
      if ((r_state == IDLE) && req_valid_i) begin
        r_addr     <= req_addr_i & c_addr_mask;
        r_snoop    <= req_snoop_i;
        r_cr       <= '0;
        r_cr_got   <= 1'b0;
        r_data     <= '0;
        r_beat_cnt <= '0;
        r_err      <= 1'b0;
      end
      if (w_collect) begin
        r_cr       <= w_cr_nxt;
        r_cr_got   <= w_cr_got_nxt;
        r_beat_cnt <= w_beat_nxt;
        for (int b = 0; b < int'(c_beats); b++) begin
          if (w_cd_hs && (r_beat_cnt == c_bw'(b))) begin
            r_data[b*DATA_WIDTH +: DATA_WIDTH] <= snoop_port_i.cd.data;
          end
        end
        if (w_err_set) r_err <= 1'b1;
        r_to_cnt <= (w_done || w_timeout) ? '0 : r_to_cnt + c_tw'(1);
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign resp_cr_o   = r_cr;
  assign resp_data_o = r_data;
  assign resp_err_o  = r_err;
  assign busy_o      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_snoop_req_initiator.sv
// ============================================================================
// tb_snoop_req_initiator : directed snoop scenarios checked against a line-level model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_snoop_req_initiator;
  import snoop_req_initiator_pkg::*;

  localparam int T = 16;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         req_valid_i = 1'b0;
  logic         req_ready_o;
  logic [63:0]  req_addr_i = '0;
  acsnoop_t     req_snoop_i = '0;
  snoop_req_t   snoop_port_o;
  snoop_resp_t  snoop_port_i = '0;
  logic         resp_valid_o;
  logic         resp_ready_i = 1'b0;
  crresp_t      resp_cr_o;
  logic [127:0] resp_data_o;
  logic         resp_err_o;
  logic         busy_o;

  always #5 clk_i = ~clk_i;

  snoop_req_initiator #(
    .LINE_WIDTH    (128),
    .DATA_WIDTH    (64),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_snoop_i (req_snoop_i),
    .snoop_port_o(snoop_port_o),
    .snoop_port_i(snoop_port_i),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .resp_cr_o   (resp_cr_o),
    .resp_data_o (resp_data_o),
    .resp_err_o  (resp_err_o),
    .busy_o      (busy_o)
  );

  typedef struct {
    logic [63:0]  ac_addr;
    acsnoop_t     snoop;
    crresp_t      cr;
    logic [127:0] data;
    logic         err;
    int           lat;
  } exp_t;

  int           n_tests = 0;
  int           n_fail  = 0;
  exp_t         exp_cur;
  bit           exp_active = 1'b0;
  int           ac_cycles, resp_cycles, last_lat;
  logic [63:0]  seen_ac_addr;
  logic [127:0] seen_data;
  logic         seen_err;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic crresp_t mk_cr(input logic dt, input logic er, input logic sh, input logic pd);
    crresp_t c;
    c = '0;
    c.DataTransfer = dt;
    c.Error        = er;
    c.IsShared     = sh;
    c.PassDirty    = pd;
    return c;
  endfunction

  // Outcome of one snoop given the collect-phase cycle at which each handshake is offered.
  function automatic exp_t model(input logic [63:0] addr, input acsnoop_t snp,
                                 input int cr_c, input crresp_t cr,
                                 input int bc0, input logic [63:0] bd0, input logic bl0,
                                 input int bc1, input logic [63:0] bd1, input logic bl1);
    exp_t e;
    int   d;
    bit   to;
    int   cnt;
    e.ac_addr = (addr / 64'd16) * 64'd16;
    e.snoop   = snp;
    e.cr      = '0;
    e.data    = '0;
    e.err     = 1'b0;
    d  = 0;
    to = 1'b0;
    if (cr_c < 0) to = 1'b1;
    else if (cr.DataTransfer) begin
      if (bc0 < 0 || bc1 < 0) to = 1'b1;
      else begin
        d = cr_c;
        if (bc0 > d) d = bc0;
        if (bc1 > d) d = bc1;
      end
    end else d = cr_c;
    if (!to && d >= T) to = 1'b1;
    if (to) d = T - 1;
    e.lat = d + 1;
    if (cr_c >= 0 && cr_c <= d) e.cr = cr;
    cnt = 0;
    if (bc0 >= 0 && bc0 <= d) begin
      e.data[63:0] = bd0;
      cnt = 1;
      if (bl0 != 1'b0) e.err = 1'b1;
    end
    if (bc1 >= 0 && bc1 <= d) begin
      e.data[127:64] = bd1;
      cnt = 2;
      if (bl1 != 1'b1) e.err = 1'b1;
    end
    if (e.cr.Error) e.err = 1'b1;
    if (cr_c >= 0 && cr_c <= d && !cr.DataTransfer && cnt > 0) e.err = 1'b1;
    if (to) e.err = 1'b1;
    return e;
  endfunction

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (snoop_port_o.ac_valid) begin
        ac_cycles++;
        seen_ac_addr = snoop_port_o.ac.addr;
        chk("ac_expected", 128'(exp_active), 128'(1));
        chk("ac_addr", 128'(snoop_port_o.ac.addr), 128'(exp_cur.ac_addr));
        chk("ac_snoop", 128'(snoop_port_o.ac.snoop), 128'(exp_cur.snoop));
        chk("ac_prot", 128'(snoop_port_o.ac.prot), 128'(0));
      end
      if (resp_valid_o) begin
        resp_cycles++;
        seen_data = resp_data_o;
        seen_err  = resp_err_o;
        chk("resp_expected", 128'(exp_active), 128'(1));
        chk("resp_cr", 128'(resp_cr_o), 128'(exp_cur.cr));
        chk("resp_data", resp_data_o, exp_cur.data);
        chk("resp_err", 128'(resp_err_o), 128'(exp_cur.err));
      end
    end
  end

  task automatic start_req(input string tn, input logic [63:0] addr, input acsnoop_t snp,
                           input int ac_delay, input exp_t e);
    for (int i = 0; i < 40 && !req_ready_o; i++) tick();
    chk({tn, "_idle_ready"}, 128'(req_ready_o), 128'(1));
    chk({tn, "_idle_busy"}, 128'(busy_o), 128'(0));
    exp_cur    = e;
    exp_active = 1'b1;
    ac_cycles  = 0;
    resp_cycles = 0;
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_snoop_i = snp;
    tick();
    req_valid_i = 1'b0;
    chk({tn, "_busy"}, 128'(busy_o), 128'(1));
    chk({tn, "_ready_low"}, 128'(req_ready_o), 128'(0));
    for (int i = 0; i < ac_delay; i++) tick();
    snoop_port_i.ac_ready = 1'b1;
    tick();
    snoop_port_i.ac_ready = 1'b0;
    chk({tn, "_ac_cycles"}, 128'(ac_cycles), 128'(ac_delay + 1));
  endtask

  task automatic run_snoop(input string tn, input logic [63:0] addr, input acsnoop_t snp,
                           input int ac_delay, input int cr_c, input crresp_t cr,
                           input int bc0, input logic [63:0] bd0, input logic bl0,
                           input int bc1, input logic [63:0] bd1, input logic bl1,
                           input int rdy_delay, input bit hold_req);
    exp_t e;
    bit   got;
    e = model(addr, snp, cr_c, cr, bc0, bd0, bl0, bc1, bd1, bl1);
    start_req(tn, addr, snp, ac_delay, e);
    got = 1'b0;
    last_lat = 0;
    for (int c = 0; c < 64 && !got; c++) begin
      snoop_port_i.cr_valid = (c == cr_c);
      snoop_port_i.cr_resp  = cr;
      snoop_port_i.cd_valid = (c == bc0) || (c == bc1);
      snoop_port_i.cd.data  = (c == bc1) ? bd1 : bd0;
      snoop_port_i.cd.last  = (c == bc1) ? bl1 : bl0;
      tick();
      snoop_port_i.cr_valid = 1'b0;
      snoop_port_i.cd_valid = 1'b0;
      if (resp_valid_o) begin
        got = 1'b1;
        last_lat = c + 1;
      end
    end
    chk({tn, "_latency"}, 128'(last_lat), 128'(e.lat));
    if (got) begin
      for (int i = 0; i < rdy_delay; i++) begin
        req_valid_i = hold_req;
        tick();
        chk({tn, "_hold_req_ready"}, 128'(req_ready_o), 128'(0));
        chk({tn, "_hold_valid"}, 128'(resp_valid_o), 128'(1));
      end
      resp_ready_i = 1'b1;
      tick();
      resp_ready_i = 1'b0;
      req_valid_i  = 1'b0;
      chk({tn, "_resp_cycles"}, 128'(resp_cycles), 128'(rdy_delay + 1));
      chk({tn, "_resp_drop"}, 128'(resp_valid_o), 128'(0));
      chk({tn, "_back_idle"}, 128'(busy_o), 128'(0));
    end
    exp_active = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    tick();
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_ac_valid", 128'(snoop_port_o.ac_valid), 128'(0));
    chk("rst_cr_ready", 128'(snoop_port_o.cr_ready), 128'(0));
    chk("rst_resp_valid", 128'(resp_valid_o), 128'(0));
    tick();
    rst_ni = 1'b1;
    tick();
    chk("rst_resp_data", resp_data_o, 128'(0));
    chk("rst_resp_cr", 128'(resp_cr_o), 128'(0));
    chk("rst_resp_err", 128'(resp_err_o), 128'(0));
    chk("rst_req_ready", 128'(req_ready_o), 128'(1));

    // ReadShared with line data, CR alongside the last beat.
    run_snoop("t1_readshared", 64'h0000_0000_8000_1234, SNP_READ_SHARED, 3,
              1, mk_cr(1, 0, 1, 0), 0, 64'hA, 1'b0, 1, 64'hB, 1'b1, 0, 1'b0);
    chk("t1_lit_addr", 128'(seen_ac_addr), 128'(64'h8000_1230));
    chk("t1_lit_data", seen_data, {64'hB, 64'hA});
    chk("t1_lit_err", 128'(seen_err), 128'(0));
    chk("t1_lit_lat", 128'(last_lat), 128'(2));

    // CleanInvalid miss: no data, result one cycle after CR.
    run_snoop("t2_clean_inv", 64'h0000_0000_0000_0040, SNP_CLEAN_INVALID, 0,
              2, mk_cr(0, 0, 0, 0), -1, 64'h0, 1'b0, -1, 64'h0, 1'b0, 0, 1'b0);
    chk("t2_lit_lat", 128'(last_lat), 128'(3));
    chk("t2_lit_data", seen_data, 128'(0));

    // Beat0 two cycles ahead of CR, beat1 together with CR.
    run_snoop("t3_order", 64'h0000_1234_5678_9ABF, SNP_READ_ONCE, 1,
              2, mk_cr(1, 0, 0, 0), 0, 64'h1111_2222_3333_4444, 1'b0,
              2, 64'h5555_6666_7777_8888, 1'b1, 0, 1'b0);
    chk("t3_lit_data", seen_data, {64'h5555_6666_7777_8888, 64'h1111_2222_3333_4444});

    // Wrong last on beat0 flags an error but the line still completes.
    run_snoop("t4_bad_last", 64'h0000_0000_0000_1000, SNP_READ_SHARED, 0,
              3, mk_cr(1, 0, 1, 0), 0, 64'hC0FFEE, 1'b1, 1, 64'hBEEF, 1'b1, 1, 1'b0);
    chk("t4_lit_err", 128'(seen_err), 128'(1));
    chk("t4_lit_lat", 128'(last_lat), 128'(4));

    // Silent cache: timeout completion.
    run_snoop("t5_timeout", 64'h0000_0000_0000_2008, SNP_MAKE_INVALID, 2,
              -1, mk_cr(0, 0, 0, 0), -1, 64'h0, 1'b0, -1, 64'h0, 1'b0, 0, 1'b0);
    chk("t5_lit_lat", 128'(last_lat), 128'(16));
    chk("t5_lit_err", 128'(seen_err), 128'(1));

    // CR error with data, result held while a new request waits.
    run_snoop("t6_err_hold", 64'h0000_0000_0000_3030, SNP_READ_UNIQUE, 0,
              0, mk_cr(1, 1, 0, 0), 0, 64'h0F0F, 1'b0, 1, 64'hF0F0, 1'b1, 5, 1'b1);
    chk("t6_lit_err", 128'(seen_err), 128'(1));
    chk("t6_lit_data", seen_data, {64'hF0F0, 64'h0F0F});

    // Data beat while CR says no data transfer.
    run_snoop("t7_dt0_beat", 64'h0000_0000_0000_4000, SNP_READ_ONCE, 0,
              1, mk_cr(0, 0, 0, 0), 0, 64'hDEAD, 1'b0, -1, 64'h0, 1'b0, 0, 1'b0);
    chk("t7_lit_err", 128'(seen_err), 128'(1));

    // Reset while collecting.
    e = model(64'h50, SNP_READ_SHARED, -1, mk_cr(0, 0, 0, 0), -1, 64'h0, 1'b0, -1, 64'h0, 1'b0);
    start_req("t8_reset", 64'h50, SNP_READ_SHARED, 0, e);
    tick();
    tick();
    rst_ni = 1'b0;
    exp_active = 1'b0;
    #1;
    chk("t8_busy", 128'(busy_o), 128'(0));
    chk("t8_ac_valid", 128'(snoop_port_o.ac_valid), 128'(0));
    chk("t8_cr_ready", 128'(snoop_port_o.cr_ready), 128'(0));
    chk("t8_resp_valid", 128'(resp_valid_o), 128'(0));
    tick();
    rst_ni = 1'b1;
    tick();
    chk("t8_req_ready", 128'(req_ready_o), 128'(1));
    chk("t8_resp_err", 128'(resp_err_o), 128'(0));

    // CR first, beats later; top-of-memory address.
    run_snoop("t9_cr_first", 64'hFFFF_FFFF_FFFF_FFFF, SNP_READ_UNIQUE, 0,
              0, mk_cr(1, 0, 0, 1), 3, 64'h0123_4567_89AB_CDEF, 1'b0,
              4, 64'hFEDC_BA98_7654_3210, 1'b1, 0, 1'b0);
    chk("t9_lit_addr", 128'(seen_ac_addr), 128'(64'hFFFF_FFFF_FFFF_FFF0));
    chk("t9_lit_lat", 128'(last_lat), 128'(5));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
